ui_mul_unit: RTL and testbench

- Multi-cycle unsigned shift-add multiplier. It is the responder side of the coprocessor functional-unit handshake.
- The CCU initiator drives `start` with operands `a_b` and `b_b`. This block computes the full-width product and answers with a one-cycle `end_step` pulse plus a held 64-bit `y_b`.
- It drops into the CCU in place of the existing functional unit, with no initiator changes.

---
 rtl/ui_mul_unit_pkg.sv | 18 +
 rtl/ui_mul_unit_if.sv | 24 ++
 rtl/ui_mul_unit_step.sv | 28 ++
 rtl/ui_mul_unit.sv | 146 ++++++++++++++
 tb/tb_ui_mul_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ui_mul_unit_pkg.sv
// Shared definitions for the ui_mul_unit shift-add multiplier.
// Holds the FSM state encodings, the default width and the counter-width helper.
package ui_mul_unit_pkg;

   localparam int UI_MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      UI_MUL_IDLE = 2'd0,
      UI_MUL_CALC = 2'd1,
      UI_MUL_DONE = 2'd2
   } ui_mul_state_t;

   // Step counter width; never narrower than one bit.
   function automatic int ui_mul_cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/ui_mul_unit_if.sv
// CCU functional-unit handshake bundle between initiator (master) and
// multiplier responder (slave).
interface ui_mul_unit_if
   import ui_mul_unit_pkg::*;
#(
   parameter int WIDTH = UI_MUL_WIDTH
);
   logic               start;
   logic [WIDTH-1:0]   a_b;
   logic [WIDTH-1:0]   b_b;
   logic [2*WIDTH-1:0] y_b;
   logic               end_step;
   logic               busy;

   modport master (
      output start, a_b, b_b,
      input  y_b, end_step, busy
   );

   modport slave (
      input  start, a_b, b_b,
      output y_b, end_step, busy
   );
endinterface

// File: rtl/ui_mul_unit_step.sv
// Combinational single step of the shift-add multiplier datapath:
// conditional accumulate, multiplicand shift left, multiplier shift right.
module ui_mul_unit_step
   import ui_mul_unit_pkg::*;
#(
   parameter int WIDTH = UI_MUL_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] a_r,
   input  logic [WIDTH-1:0]   b_r,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic [2*WIDTH-1:0] a_nxt,
   output logic [WIDTH-1:0]   b_nxt
);

   // One radix-2 step; the add wraps modulo 2^(2*WIDTH) by construction.
   always_comb begin
      acc_nxt = acc;
      a_nxt   = a_r << 1;
      b_nxt   = b_r >> 1;
      if (b_r[0]) begin
         acc_nxt = acc + a_r;
      end else begin
         acc_nxt = acc;
      end
   end

endmodule

// File: rtl/ui_mul_unit.sv
// Multi-cycle unsigned shift-add multiplier, responder side of the CCU handshake.
// Optional UI_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module ui_mul_unit
   import ui_mul_unit_pkg::*;
#(
   parameter int WIDTH = UI_MUL_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   ui_mul_unit_if.slave  bus
);

   localparam int            CW       = ui_mul_cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   ui_mul_state_t      state_r;
   ui_mul_state_t      state_nxt_s;
   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] a_r;
   logic [WIDTH-1:0]   b_r;
   logic [CW-1:0]      cnt_r;
   logic [2*WIDTH-1:0] acc_nxt_s;
   logic [2*WIDTH-1:0] a_nxt_s;
   logic [WIDTH-1:0]   b_nxt_s;
   logic               last_s;
   logic [2*WIDTH-1:0] y_r;
   logic               end_r;
   logic               busy_r;

   ui_mul_unit_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc_r),
      .a_r     (a_r),
      .b_r     (b_r),
      .acc_nxt (acc_nxt_s),
      .a_nxt   (a_nxt_s),
      .b_nxt   (b_nxt_s)
   );

   // Detect the final CALC step.
   always_comb begin
      last_s = 1'b0;
`ifdef UI_MUL_EARLY_EXIT_EN
      if ((cnt_r == CNT_LAST) || (b_nxt_s == {WIDTH{1'b0}})) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
`else
      if (cnt_r == CNT_LAST) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
`endif
   end

   // Next-state logic; DONE waits for start to drop so a held request is not re-accepted.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         UI_MUL_IDLE: begin
            if (bus.start) begin
               state_nxt_s = UI_MUL_CALC;
            end else begin
               state_nxt_s = UI_MUL_IDLE;
            end
         end
         UI_MUL_CALC: begin
            if (last_s) begin
               state_nxt_s = UI_MUL_DONE;
            end else begin
               state_nxt_s = UI_MUL_CALC;
            end
         end
         UI_MUL_DONE: begin
            if (bus.start) begin
               state_nxt_s = UI_MUL_DONE;
            end else begin
               state_nxt_s = UI_MUL_IDLE;
            end
         end
         default: state_nxt_s = UI_MUL_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= UI_MUL_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand capture on accept, then one shift-add step per CALC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {(2*WIDTH){1'b0}};
         a_r   <= {(2*WIDTH){1'b0}};
         b_r   <= {WIDTH{1'b0}};
         cnt_r <= {CW{1'b0}};
      end else begin
         case (state_r)
            UI_MUL_IDLE: begin
               if (bus.start) begin
                  acc_r <= {(2*WIDTH){1'b0}};
                  a_r   <= {{WIDTH{1'b0}}, bus.a_b};
                  b_r   <= bus.b_b;
                  cnt_r <= {CW{1'b0}};
               end
            end
            UI_MUL_CALC: begin
               acc_r <= acc_nxt_s;
               a_r   <= a_nxt_s;
               b_r   <= b_nxt_s;
               cnt_r <= cnt_r + CW'(1);
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

   // Registered outputs: product held until the next completion, one-cycle end pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_r    <= {(2*WIDTH){1'b0}};
         end_r  <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s == UI_MUL_CALC);
         if ((state_r == UI_MUL_CALC) && last_s) begin
            y_r   <= acc_nxt_s;
            end_r <= 1'b1;
         end else begin
            end_r <= 1'b0;
         end
      end
   end

   assign bus.y_b      = y_r;
   assign bus.end_step = end_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_ui_mul_unit.sv
// Scoreboard bench for ui_mul_unit: the driver pushes expected product and latency,
// a negedge monitor pops and checks on every end_step. Honours UI_MUL_EARLY_EXIT_EN.
module tb_ui_mul_unit;

   typedef struct {
      logic [63:0] prod;
      int          lat;
      int          acc_cyc;
   } sb_item_t;

   logic     clk;
   logic     rst;
   int       cyc;
   int       total;
   int       bad;
   logic [63:0] last_prod;
   sb_item_t exp_q[$];
   sb_item_t mon_it;

   ui_mul_unit_if #(.WIDTH(32)) bus ();

   ui_mul_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference latency from the multiplier operand alone.
   function automatic int exp_lat(input logic [31:0] b);
      int hi;
      hi = -1;
`ifdef UI_MUL_EARLY_EXIT_EN
      for (int i = 0; i < 32; i++) if (b[i]) hi = i;
      return (hi + 1 < 1) ? 1 : hi + 1;
`else
      return 32 + hi - hi;
`endif
   endfunction

   // Monitor: every completion pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst && bus.end_step) begin
         if (exp_q.size() == 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL unexpected_end_step: got end_step=1 at cycle %0d want none", cyc);
         end else begin
            mon_it = exp_q.pop_front();
            check("product", bus.y_b, mon_it.prod);
            check("latency", 64'(cyc - mon_it.acc_cyc), 64'(mon_it.lat));
         end
      end
   end

   // Issue one operation; assumes it is called just after a negedge with the unit idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit perturb);
      sb_item_t it;
      int n;
      bus.a_b   = a;
      bus.b_b   = b;
      bus.start = 1'b1;
      it.prod    = {32'd0, a} * {32'd0, b};
      it.lat     = exp_lat(b);
      it.acc_cyc = cyc + 1;
      exp_q.push_back(it);
      @(negedge clk);
      check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
      check("y_held_after_accept", bus.y_b, last_prod);
      n = 0;
      while (!bus.end_step && n < 200) begin
         if (perturb && n >= 2 && n <= 8) begin
            bus.a_b   = 32'd100;
            bus.b_b   = 32'd100;
            bus.start = n[0];
         end else begin
            bus.start = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      if (!bus.end_step) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL end_step_timeout: got no end_step in %0d cycles want one", n);
      end else begin
         last_prod = it.prod;
         check("busy_at_end", {63'd0, bus.busy}, 64'd0);
      end
      bus.start = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         check("busy_while_held", {63'd0, bus.busy}, 64'd0);
         check("y_while_held", bus.y_b, last_prod);
      end
      bus.start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      total     = 0;
      bad       = 0;
      cyc       = 0;
      last_prod = 64'd0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a_b   = 32'd0;
      bus.b_b   = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_y", bus.y_b, 64'd0);
      check("reset_end", {63'd0, bus.end_step}, 64'd0);
      check("reset_busy", {63'd0, bus.busy}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(32'd3, 32'd5, 0, 1'b0);
      check("y_3x5", bus.y_b, 64'h0000_0000_0000_000F);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      check("y_max", bus.y_b, 64'hFFFF_FFFE_0000_0001);
      run_op(32'd10, 32'd11, 5, 1'b0);
      run_op(32'd7, 32'd6, 0, 1'b0);
      check("y_7x6", bus.y_b, 64'd42);
      run_op(32'd3, 32'd5, 0, 1'b1);
      check("y_perturbed", bus.y_b, 64'd15);
      run_op(32'd5, 32'd0, 0, 1'b0);
      check("y_b_zero", bus.y_b, 64'd0);
      run_op(32'd3, 32'h10, 0, 1'b0);
      check("y_3x16", bus.y_b, 64'h30);

      // Asynchronous reset in the middle of an operation discards it.
      bus.a_b   = 32'd9;
      bus.b_b   = 32'd9;
      bus.start = 1'b1;
      exp_q.push_back('{prod: 64'd81, lat: exp_lat(32'd9), acc_cyc: cyc + 1});
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_y", bus.y_b, 64'd0);
      check("abort_end", {63'd0, bus.end_step}, 64'd0);
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      exp_q.delete();
      last_prod = 64'd0;
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run_op(32'd2, 32'd2, 0, 1'b0);
      check("y_2x2", bus.y_b, 64'd4);

      for (int k = 0; k < 20; k++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(0, 255);
            1:       rb = 32'd1 << $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
